// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the load/store stage.
// Data has fixed priority, and a starvation counter forces a fetch grant eventually.
module mem_port_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      fetch_req_valid,
    input  logic [ADDRESS_WIDTH-1:0]  fetch_req_address,
    output logic                      fetch_req_ready,
    input  logic                      fetch_flush,
    output logic                      fetch_resp_valid,
    output logic [DATA_WIDTH-1:0]     fetch_resp_data,
    input  logic                      data_req_valid,
    input  logic                      data_req_write,
    input  logic [ADDRESS_WIDTH-1:0]  data_req_address,
    input  logic [DATA_WIDTH-1:0]     data_req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   data_req_byte_enable,
    output logic                      data_req_ready,
    output logic                      data_resp_valid,
    output logic [DATA_WIDTH-1:0]     data_resp_rdata,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic                      mem_req_write,
    output logic [ADDRESS_WIDTH-1:0]  mem_req_address,
    output logic [DATA_WIDTH-1:0]     mem_req_wdata,
    output logic [DATA_WIDTH/8-1:0]   mem_req_byte_enable,
    input  logic                      mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]     mem_resp_rdata,
    output logic                      busy
);

    localparam int STARVE_WIDTH = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_WIDTH-1:0] STARVE_MAX = STARVE_WIDTH'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t                  r_state;
    logic                    r_ownerData;
    logic                    r_drop;
    logic [STARVE_WIDTH-1:0] r_starveCount;

    logic w_idle;
    logic w_fetchWins;
    logic w_dropNow;

    // Readies depend only on state, starvation count and request valids.
    assign w_idle          = (r_state == IDLE) && !reset;
    assign w_fetchWins     = fetch_req_valid && (!data_req_valid || (r_starveCount == STARVE_MAX));
    assign fetch_req_ready = w_idle && w_fetchWins;
    assign data_req_ready  = w_idle && data_req_valid && !w_fetchWins;

    assign w_dropNow     = r_drop || (fetch_flush && !r_ownerData);
    assign mem_req_valid = (r_state == REQ);
    assign busy          = (r_state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state             <= IDLE;
            r_ownerData         <= 1'b0;
            r_drop              <= 1'b0;
            r_starveCount       <= '0;
            mem_req_write       <= 1'b0;
            mem_req_address     <= '0;
            mem_req_wdata       <= '0;
            mem_req_byte_enable <= '0;
            fetch_resp_valid    <= 1'b0;
            fetch_resp_data     <= '0;
            data_resp_valid     <= 1'b0;
            data_resp_rdata     <= '0;
        end else begin
            fetch_resp_valid <= 1'b0;
            data_resp_valid  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (fetch_req_ready) begin
                        r_state             <= REQ;
                        r_ownerData         <= 1'b0;
                        r_drop              <= fetch_flush;
                        r_starveCount       <= '0;
                        mem_req_write       <= 1'b0;
                        mem_req_address     <= fetch_req_address;
                        mem_req_wdata       <= '0;
                        mem_req_byte_enable <= '1;
                    end else if (data_req_ready) begin
                        r_state             <= REQ;
                        r_ownerData         <= 1'b1;
                        r_drop              <= 1'b0;
                        mem_req_write       <= data_req_write;
                        mem_req_address     <= data_req_address;
                        mem_req_wdata       <= data_req_wdata;
                        mem_req_byte_enable <= data_req_byte_enable;
                        if (!fetch_req_valid) begin
                            r_starveCount <= '0;
                        end else if (r_starveCount != STARVE_MAX) begin
                            r_starveCount <= r_starveCount + STARVE_WIDTH'(1);
                        end
                    end
                end
                REQ: begin
                    r_drop <= w_dropNow;
                    if (mem_req_ready) begin
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    // A flush arriving alongside the memory response still drops it.
                    if (mem_resp_valid) begin
                        r_state <= IDLE;
                        r_drop  <= 1'b0;
                        if (r_ownerData) begin
                            data_resp_valid <= 1'b1;
                            data_resp_rdata <= mem_req_write ? '0 : mem_resp_rdata;
                        end else if (!w_dropNow) begin
                            fetch_resp_valid <= 1'b1;
                            fetch_resp_data  <= mem_resp_rdata;
                        end
                    end else begin
                        r_drop <= w_dropNow;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
